// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared definitions for the SRAM access controller.
//   ADDR_W  - SRAM macro address width (2048 entries)
//   state_t - controller FSM states
//   gnt_t   - per-cycle arbitration result
package sram_ctrl_pkg;

    localparam int unsigned ADDR_W = 11;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD
    } gnt_t;

endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// sram_ctrl_rsp_fifo: synchronous FIFO holding SRAM read responses.
// Ports:
//   clk, reset_n       - clock, synchronous active-low reset
//   push, push_data    - enqueue one word (caller guarantees space)
//   pop                - dequeue head word (caller guarantees not empty)
//   valid, head        - FIFO non-empty, head-of-queue word
//   count              - current number of stored entries
module sram_ctrl_rsp_fifo #(
    parameter int unsigned width     = 64,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic [width-1:0]               push_data,
    input  logic                           pop,
    output logic                           valid,
    output logic [width-1:0]               head,
    output logic [$clog2(RSP_DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(RSP_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [width-1:0] mem [RSP_DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign valid = (count != '0);
    assign head  = mem[rptr];

endmodule

// File: rtl/sram_w2048_ctrl.sv
// sram_w2048_ctrl: initiator for a 2048-entry single-port SRAM macro
// (CEN/WEN active-low, registered address, Q valid one cycle after read).
// Arbitrates a valid/ready write port and read port onto the macro and
// returns read data in order through a credit-protected response FIFO.
// Ports:
//   clk, reset_n                     - clock, synchronous active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data - write request port
//   rd_valid/rd_ready/rd_addr         - read request port
//   rsp_valid/rsp_ready/rsp_data      - in-order read response port
//   busy                              - not accepting requests
//   sram_cen/wen/a/d, sram_q          - SRAM macro pins
// Build option: define SRAM_W2048_CTRL_CLEAR_EN to zero-fill the whole
// array (one word per cycle) after every reset before accepting requests.
module sram_w2048_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned width     = 64,
    parameter int unsigned num       = 2048,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [width-1:0]  wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [width-1:0]  rsp_data,
    output logic              busy,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [width-1:0]  sram_d,
    input  logic [width-1:0]  sram_q
);

    localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;

    if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0 || num == 0 || num > 2048) begin : g_param_check
        $error("sram_w2048_ctrl: illegal num/RSP_DEPTH");
    end

    state_t            state;
    gnt_t              gnt;
    logic              rr_rd;      // 1: read wins the next contested cycle
    logic              inflight;   // read issued last cycle, Q valid now
    logic              run;
    logic              credit_ok;
    logic              rd_req;
    logic              contested;
    logic [ADDR_W-1:0] a_q;
    logic [width-1:0]  d_q;
    logic              fifo_valid;
    logic [CW-1:0]     fifo_count;
`ifdef SRAM_W2048_CTRL_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt;
`endif

    assign run       = reset_n && (state == RUN);
    // Entries already buffered plus the one about to land; a same-cycle
    // pop is deliberately not credited.
    assign credit_ok = (int'(fifo_count) + int'(inflight)) < int'(RSP_DEPTH);
    assign rd_req    = rd_valid && credit_ok;
    assign contested = run && wr_valid && rd_req;

    always_comb begin
        gnt = GNT_NONE;
        if (run) begin
            if (wr_valid && rd_req) begin
                gnt = rr_rd ? GNT_RD : GNT_WR;
            end else if (wr_valid) begin
                gnt = GNT_WR;
            end else if (rd_req) begin
                gnt = GNT_RD;
            end
        end
    end

    assign wr_ready = (gnt == GNT_WR);
    assign rd_ready = (gnt == GNT_RD);

    // Address/data pins hold their last driven value on idle cycles.
    always_comb begin
        sram_cen = 1'b1;
        sram_wen = 1'b1;
        sram_a   = a_q;
        sram_d   = d_q;
`ifdef SRAM_W2048_CTRL_CLEAR_EN
        if (reset_n && state == CLEAR) begin
            sram_cen = 1'b0;
            sram_wen = 1'b0;
            sram_a   = clr_cnt;
            sram_d   = '0;
        end else
`endif
        begin
            case (gnt)
                GNT_WR: begin
                    sram_cen = 1'b0;
                    sram_wen = 1'b0;
                    sram_a   = wr_addr;
                    sram_d   = wr_data;
                end
                GNT_RD: begin
                    sram_cen = 1'b0;
                    sram_a   = rd_addr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
`ifdef SRAM_W2048_CTRL_CLEAR_EN
            state   <= CLEAR;
            clr_cnt <= '0;
`else
            state   <= RUN;
`endif
            rr_rd    <= 1'b0;
            inflight <= 1'b0;
            a_q      <= '0;
            d_q      <= '0;
        end else begin
            inflight <= (gnt == GNT_RD);
            a_q      <= sram_a;
            d_q      <= sram_d;
            if (contested) begin
                rr_rd <= ~rr_rd;
            end
`ifdef SRAM_W2048_CTRL_CLEAR_EN
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + ADDR_W'(1);
                if (clr_cnt == ADDR_W'(num - 1)) begin
                    state <= RUN;
                end
            end
`endif
        end
    end

    sram_ctrl_rsp_fifo #(
        .width     (width),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (sram_q),
        .pop       (rsp_valid && rsp_ready),
        .valid     (fifo_valid),
        .head      (rsp_data),
        .count     (fifo_count)
    );

    assign rsp_valid = reset_n && fifo_valid;
    assign busy      = !reset_n || (state != RUN);

endmodule

// File: tb/tb_sram_w2048_ctrl.sv
// tb_sram_w2048_ctrl: self-checking bench for sram_w2048_ctrl with a
// behavioural SRAM macro, a reference memory and an in-order response
// scoreboard.
module tb_sram_w2048_ctrl;

    localparam int unsigned W = 64;
    localparam int unsigned N = 2048;
    localparam int unsigned D = 4;

    logic          clk;
    logic          reset_n;
    logic          wr_valid, wr_ready;
    logic [10:0]   wr_addr;
    logic [W-1:0]  wr_data;
    logic          rd_valid, rd_ready;
    logic [10:0]   rd_addr;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          busy;
    logic          sram_cen, sram_wen;
    logic [10:0]   sram_a;
    logic [W-1:0]  sram_d;
    logic [W-1:0]  sram_q;

    sram_w2048_ctrl #(
        .width     (W),
        .num       (N),
        .RSP_DEPTH (D)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] mem     [N];
    logic [W-1:0] ref_mem [N];
    logic [W-1:0] exp_q   [$];
    int n_pass  = 0;
    int n_total = 0;

    // SRAM macro model: registered address, Q valid the cycle after a read.
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_a] <= sram_d;
            else           sram_q      <= mem[sram_a];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: accepted reads push the reference word, responses pop it.
    always @(negedge clk) begin
        if (reset_n) begin
            if (wr_valid && wr_ready) ref_mem[wr_addr] = wr_data;
            if (rd_valid && rd_ready) exp_q.push_back(ref_mem[rd_addr]);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL rsp_unexpected: got %0h expected no response at %0t", rsp_data, $time);
                end else begin
                    chk("rsp_data", rsp_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        reset_n = 1'b1;
`ifdef SRAM_W2048_CTRL_CLEAR_EN
        for (int unsigned i = 0; i < N; i++) ref_mem[i] = '0;
        for (int i = 0; i < 3000 && busy; i++) tick();
        @(negedge clk);
        chk("clear_done_busy", busy, 0);
        tick();
`else
        @(negedge clk);
        chk("post_reset_busy", busy, 0);
        tick();
`endif
    endtask

    typedef struct {
        logic        wv;
        logic [10:0] wa;
        logic [63:0] wd;
        logic        rv;
        logic [10:0] ra;
        logic        e_wrdy;
        logic        e_rrdy;
        logic        e_cen;
        logic        e_wen;
        logic [10:0] e_a;
        logic        e_rspv;
    } vec_t;

    vec_t tbl [14];

    initial begin
        for (int unsigned i = 0; i < N; i++) begin
            mem[i]     = 64'hC0DE_0000_0000_0000 | 64'(i * 3 + 7);
            ref_mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i * 3 + 7);
        end
        reset_n = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b1;
        wr_addr = '0; wr_data = '0; rd_addr = '0;

        // ---- reset state with both requests asserted
        tick(); tick();
        @(negedge clk);
        chk("rst_cen", sram_cen, 1);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 1);
        tick();
        rd_valid = 1'b0;

`ifdef SRAM_W2048_CTRL_CLEAR_EN
        // ---- clear walk: write held, every word zeroed in address order
        reset_n = 1'b1;
        for (int unsigned i = 0; i < N; i++) ref_mem[i] = '0;
        for (int unsigned i = 0; i < N; i++) begin
            @(negedge clk);
            chk("clear_a", sram_a, i);
            chk("clear_ctl", {wr_ready, sram_cen, sram_wen, busy, sram_d == '0}, 5'b00011);
            tick();
        end
        @(negedge clk);
        chk("clear_end_busy", busy, 0);
        chk("clear_end_wr_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
`else
        wr_valid = 1'b0;
        release_reset();
`endif

        // ---- table: write/read latency, then contested round-robin
        tbl[0] = '{1, 5, 64'hA5A5, 0, 0, 1, 0, 0, 0, 5, 0};
        tbl[1] = '{0, 0, 0,        1, 5, 0, 1, 0, 1, 5, 0};
        tbl[2] = '{0, 0, 0,        0, 0, 0, 0, 1, 1, 5, 0};
        tbl[3] = '{0, 0, 0,        0, 0, 0, 0, 1, 1, 5, 1};
        tbl[4] = '{0, 0, 0,        0, 0, 0, 0, 1, 1, 5, 0};
        for (int i = 0; i < 6; i++) begin
            logic wgr;
            wgr = (i % 2 == 0);
            tbl[5 + i] = '{1, 11'(16 + i), 64'h1000 + 64'(i), 1, 11'(15 + i),
                           wgr, !wgr, 0, !wgr, wgr ? 11'(16 + i) : 11'(15 + i),
                           (i == 3 || i == 5)};
        end
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 20, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 20, 1};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 20, 0};
        rsp_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            rd_valid = tbl[i].rv; rd_addr = tbl[i].ra;
            @(negedge clk);
            chk($sformatf("v%0d_wr_ready", i), wr_ready, tbl[i].e_wrdy);
            chk($sformatf("v%0d_rd_ready", i), rd_ready, tbl[i].e_rrdy);
            chk($sformatf("v%0d_cen", i), sram_cen, tbl[i].e_cen);
            chk($sformatf("v%0d_wen", i), sram_wen, tbl[i].e_wen);
            chk($sformatf("v%0d_a", i), sram_a, tbl[i].e_a);
            chk($sformatf("v%0d_rsp_valid", i), rsp_valid, tbl[i].e_rspv);
            tick();
        end
        wr_valid = 1'b0; rd_valid = 1'b0;

        // ---- burst of 8 reads, full throughput
        for (int i = 0; i < 10; i++) begin
            rd_valid = (i < 8);
            rd_addr  = 11'(i);
            @(negedge clk);
            if (i < 8)  chk($sformatf("burst_rd_ready%0d", i), rd_ready, 1);
            if (i >= 2) chk($sformatf("burst_rsp_valid%0d", i), rsp_valid, 1);
            tick();
        end
        @(negedge clk);
        chk("burst_rsp_done", rsp_valid, 0);
        tick();

        // ---- backpressure: only RSP_DEPTH reads accepted, then drained
        rsp_ready = 1'b0;
        begin
            int k;
            k = 0;
            for (int c = 0; c < 8; c++) begin
                rd_valid = (k < 8);
                rd_addr  = 11'(k);
                @(negedge clk);
                chk($sformatf("bp_rd_ready%0d", c), rd_ready, (c < 4));
                if (rd_ready) k++;
                tick();
            end
        end
        rd_valid = 1'b0;
        @(negedge clk);
        chk("bp_rsp_held", rsp_valid, 1);
        chk("bp_buffered", exp_q.size(), 4);
        tick();
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("bp_drained", exp_q.size(), 0);

        // ---- reset with 2 buffered and 1 inflight
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_valid = 1'b1;
            rd_addr  = 11'(100 + i);
            @(negedge clk);
            chk($sformatf("mid_rd_ready%0d", i), rd_ready, 1);
            tick();
        end
        rd_valid = 1'b0;
        reset_n  = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_cen", sram_cen, 1);
        chk("mid_rst_busy", busy, 1);
        tick();
        exp_q.delete();
        rsp_ready = 1'b1;
        release_reset();
        for (int i = 0; i < 6; i++) tick();
        @(negedge clk);
        chk("mid_no_stale", rsp_valid, 0);
        tick();

        // ---- read-back of the array ends after clear/reset
        rd_valid = 1'b1; rd_addr = 11'd1000;
        tick();
        rd_addr = 11'd2047;
        tick();
        rd_valid = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_w2048_ctrl.md
Name: sram_w2048_ctrl

Overview:
- Initiator/controller for the 2048-entry single-port SRAM macro (CEN/WEN active-low, registered read address, Q valid the cycle after a read).
- Converts a valid/ready write port and a valid/ready read-request port into SRAM accesses.
- Returns read data in order on a valid/ready response port, buffered so downstream backpressure never loses data.
- Sits between core datapath (L0/OFIFO drains, PSUM writeback) and each activation/weight/psum SRAM instance.

Parameters:
- width, 64, SRAM word width in bits.
- num, 2048, SRAM depth; address width fixed at 11.
- RSP_DEPTH, 4, response buffer entries; power of two, >= 2.

Ports:
- clk  input  1  clock, all state on posedge.
- reset_n  input  1  synchronous active-low reset.
- wr_valid  input  1  write request valid.
- wr_ready  output  1  write request accepted this cycle.
- wr_addr  input  11  write address.
- wr_data  input  width  write data.
- rd_valid  input  1  read request valid.
- rd_ready  output  1  read request accepted this cycle.
- rd_addr  input  11  read address.
- rsp_valid  output  1  response data valid.
- rsp_ready  input  1  downstream accepts response.
- rsp_data  output  width  read data, in request order.
- busy  output  1  controller not accepting requests (reset/clear).
- sram_cen  output  1  SRAM chip enable, active-low.
- sram_wen  output  1  SRAM write enable, low = write.
- sram_a  output  11  SRAM address.
- sram_d  output  width  SRAM write data.
- sram_q  input  width  SRAM read data.

Behaviour:
- Reset (reset_n=0 at posedge): FSM -> CLEAR (macro on) or RUN (macro off); response buffer empty; inflight=0; arbitration pointer = write-first. While reset_n=0: sram_cen=1, wr_ready=rd_ready=0, rsp_valid=0, busy=1.
- Request handshakes:
  - Accept when valid && ready at posedge.
  - SRAM pins are combinational from the granted request in the same cycle: write -> cen=0, wen=0, a=wr_addr, d=wr_data; read -> cen=0, wen=1, a=rd_addr.
  - No grant -> cen=1, wen=1; a and d hold their last driven values.
- Read issue: rd_ready=1 only if state=RUN and (buffer count + inflight) < RSP_DEPTH. A pop in the same cycle is not credited.
- Arbitration (RUN):
  - Only one valid -> that port granted.
  - Both valid and read eligible -> grant follows the pointer; pointer toggles after each contested grant (round-robin).
  - Read ineligible -> write granted.
  - Ungranted port ready=0.
- Read latency:
  - Read accepted in cycle t -> inflight=1 in t+1; sram_q captured into the buffer at the end of t+1.
  - rsp_valid=1 from cycle t+2; minimum latency 2.
  - Back-to-back reads sustain 1/cycle with RSP_DEPTH=4 and rsp_ready=1.
- Response buffer: FIFO; rsp_data = head entry. Pop on rsp_valid && rsp_ready. Push and pop in the same cycle allowed, count unchanged. Overflow is impossible by the credit rule.
- Ordering: single port, strictly in grant order. A read issued the cycle after a write to the same address returns the new data. Write-then-read on the same address in one cycle cannot occur (one grant per cycle).
- Address out of range (>= num when num < 2048): passed through unchecked.
- busy = (state != RUN).

Optional Feature:
- Macro SRAM_W2048_CTRL_CLEAR_EN.
- Defined:
  - After reset, FSM in CLEAR drives cen=0, wen=0, d=0, a = clear counter 0..num-1, one word per cycle; requests are not accepted.
  - When a = num-1 is written, the next state is RUN. CLEAR lasts num cycles; busy=1 throughout.
  - Reset asserted mid-clear restarts the counter at 0.
- Undefined: no CLEAR state; RUN on the first cycle after reset deassertion.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - Address width constant (11).
  - FSM state typedef {CLEAR, RUN}.
  - Arbitration grant encoding {GNT_NONE, GNT_WR, GNT_RD}.
- One sub-module, sram_ctrl_rsp_fifo: parameterised width/RSP_DEPTH sync FIFO with count output, same clk/reset_n.

Test Plan:
- Write 0xA5A5 to addr 5 (cycle t), read addr 5 (t+1) -> sram_cen=0/wen=0 at t; rsp_valid at t+3 with rsp_data=0xA5A5.
- Reads of addr 0..7 on consecutive cycles, rsp_ready=1 -> rd_ready stays 1; 8 responses on consecutive cycles in order.
- Same read burst with rsp_ready=0 -> rd_ready drops after 4 accepts; raise rsp_ready -> all 4 drain in order, no data lost.
- wr_valid and rd_valid held together for 6 cycles -> grants alternate W,R,W,R,W,R; pointer starts at write after reset.
- Reset asserted with 2 responses buffered and 1 inflight -> next cycle rsp_valid=0, sram_cen=1, busy=1; no stale response afterwards.
- Macro on: reset then hold wr_valid -> wr_ready=0 for 2048 cycles, sram_a walks 0..2047 with sram_d=0; any address reads back 0; busy falls in cycle 2049.
